// File: rtl/serial_arith_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_arith_pkg : shared types/helpers for bit-serial arithmetic |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  // Bit counter width able to hold 0 .. width-1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_sub_1b.sv
`default_nettype none
// +------------------------------------------------------------------+
// | full_sub_1b : combinational 1-bit full subtractor (a - b - bin)   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module full_sub_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_sub_1b
`default_nettype wire

// File: rtl/serial_sub_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | serial_sub_unit : bit-serial LSB-first subtractor a - b - bin     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module serial_sub_unit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_res_sh;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_brw_next;
  logic [WIDTH-1:0] w_res_next;

  full_sub_1b u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_brw_next)
  );

  // Newest bit enters at the MSB; after WIDTH shifts bit 0 holds the first result bit.
  assign w_res_next = {w_d, r_res_sh};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_brw   <= bin;
            r_cnt   <= '0;
            ready   <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_brw    <= w_brw_next;
          r_res_sh <= w_res_next[WIDTH-1:1];
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST) begin
            diff    <= w_res_next;
            bout    <= w_brw_next;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_sub_unit
`default_nettype wire
